// File: rtl/tile_band_display.sv
// Multi-band tiled strip renderer with ping-pong band registers and a 2-stage pixel path.
// Optional runtime palette writes are enabled by defining TILE_BAND_PALETTE_WRITE_EN.
module tile_band_display #(
  parameter logic [5:0]  COMPONENT_ID = 6'b001111,
  parameter int          NUM_BANDS    = 4,
  parameter int          TILE_W       = 16,
  parameter int          TILE_H       = 32,
  parameter int          MEM_WORDS    = 256,
  parameter int          H_ACTIVE     = 640,
  parameter int          SWAP_LINE    = 480,
  parameter logic [23:0] BG_COLOR     = 24'h202020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [23:0] RGB_output
);

  localparam int CW        = $clog2(TILE_W);
  localparam int MW        = $clog2(MEM_WORDS);
  localparam int AW        = 24;
  localparam int TILE_PIX  = TILE_W * TILE_H;
  localparam int NUM_TILES = (2 * MEM_WORDS) / TILE_PIX;

  // Tile ROM content: word w holds lo pixel (w[2:1]+w[4:3]) and hi pixel lo+1.
  function automatic logic [3:0] rom_pattern(input int w);
    logic [1:0] lo;
    lo = 2'(w >> 1) + 2'(w >> 3);
    return {lo + 2'd1, lo};
  endfunction

  function automatic logic [23:0] pal_default(input logic [1:0] idx);
    case (idx)
      2'd0:    return 24'h202020;
      2'd1:    return 24'hFFFFFF;
      2'd2:    return 24'h808080;
      default: return 24'hD3D3D3;
    endcase
  endfunction

  logic [5:0]  sub_comp;
  logic [4:0]  child_comp;
  logic [3:0]  info;
  logic [2:0]  input_type;
  logic        buffer_state;
  logic [12:0] msg;

  assign sub_comp     = writedata[31:26];
  assign child_comp   = writedata[25:21];
  assign info         = writedata[20:17];
  assign input_type   = writedata[16:14];
  assign buffer_state = writedata[13];
  assign msg          = writedata[12:0];

  logic cfg_wr, band_wr, swap_req, commit, tile_ok;
  logic active_bank, pending_bank, swap_pending;

  assign cfg_wr   = write && (info == 4'h1) && (sub_comp == COMPONENT_ID);
  assign band_wr  = cfg_wr && (32'(child_comp) < NUM_BANDS);
  assign swap_req = write && (info == 4'hF);
  assign commit   = swap_pending && (vcount == 10'(SWAP_LINE)) && (hcount == 10'd0);
  assign tile_ok  = 32'(msg[4:0]) < NUM_TILES;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_bank  <= 1'b0;
      pending_bank <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (commit) begin
        active_bank  <= pending_bank;
        swap_pending <= 1'b0;
      end
      // A request in the commit cycle re-arms for the next frame.
      if (swap_req) begin
        pending_bank <= buffer_state;
        swap_pending <= 1'b1;
      end
    end
  end

  logic       enable_reg   [2][NUM_BANDS];
  logic       mirror_reg   [2][NUM_BANDS];
  logic [4:0] tile_sel_reg [2][NUM_BANDS];
  logic [9:0] x_scroll_reg [2][NUM_BANDS];
  logic [9:0] band_y_reg   [2][NUM_BANDS];
  logic [9:0] l_edge_reg, r_edge_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int bk = 0; bk < 2; bk++) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          enable_reg[bk][b]   <= 1'b0;
          mirror_reg[bk][b]   <= 1'b0;
          tile_sel_reg[bk][b] <= 5'd0;
          x_scroll_reg[bk][b] <= 10'd0;
          band_y_reg[bk][b]   <= 10'd0;
        end
      end
    end else begin
      for (int bk = 0; bk < 2; bk++) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          if (band_wr && (buffer_state == 1'(bk)) && (child_comp == 5'(b))) begin
            case (input_type)
              3'b001: begin
                enable_reg[bk][b] <= msg[12];
                mirror_reg[bk][b] <= msg[11];
                if (tile_ok) tile_sel_reg[bk][b] <= msg[4:0];
              end
              3'b010:  x_scroll_reg[bk][b] <= msg[9:0];
              3'b011:  band_y_reg[bk][b]   <= msg[9:0];
              default: ;
            endcase
          end
          // Placed after the write so the enable-clear wins on a collision.
          if (commit && (pending_bank != 1'(bk))) enable_reg[bk][b] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_edge_reg <= 10'd0;
      r_edge_reg <= 10'(H_ACTIVE);
    end else if (band_wr) begin
      if (input_type == 3'b100) l_edge_reg <= msg[9:0];
      if (input_type == 3'b101) r_edge_reg <= msg[9:0];
    end
  end

  // Stage 1: per-band hit test and ROM address, lowest index wins.
  logic                 in_x;
  logic [NUM_BANDS-1:0] band_hit;
  logic [AW-1:0]        band_addr [NUM_BANDS];

  assign in_x = (hcount >= l_edge_reg) && (hcount < r_edge_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
      logic [9:0]    by, xs, row;
      logic [10:0]   y_sum, y_end;
      logic [CW-1:0] col, col_m;
      logic          in_y;
      assign by     = band_y_reg[active_bank][gi];
      assign xs     = x_scroll_reg[active_bank][gi];
      assign y_sum  = {1'b0, by} + 11'(TILE_H);
      assign y_end  = (y_sum > 11'd1023) ? 11'd1023 : y_sum;
      assign in_y   = ({1'b0, vcount} >= {1'b0, by}) && ({1'b0, vcount} < y_end);
      assign row    = vcount - by;
      assign col    = CW'(hcount + xs);
      assign col_m  = mirror_reg[active_bank][gi] ? (CW'(TILE_W - 1) - col) : col;
      assign band_hit[gi]  = enable_reg[active_bank][gi] && in_y && in_x;
      assign band_addr[gi] = AW'(tile_sel_reg[active_bank][gi]) * AW'(TILE_PIX)
                           + AW'(row) * AW'(TILE_W) + AW'(col_m);
    end
  endgenerate

  logic          win_hit;
  logic [AW-1:0] win_addr;

  always_comb begin
    win_hit  = 1'b0;
    win_addr = '0;
    for (int b = NUM_BANDS - 1; b >= 0; b--) begin
      if (band_hit[b]) begin
        win_hit  = 1'b1;
        win_addr = band_addr[b];
      end
    end
  end

  logic          s1_hit_reg;
  logic [AW-1:0] s1_addr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_hit_reg  <= 1'b0;
      s1_addr_reg <= '0;
    end else begin
      s1_hit_reg  <= win_hit;
      s1_addr_reg <= win_addr;
    end
  end

  // Stage 2: ROM lookup and palette, registered into RGB_output.
  logic [3:0] mem [MEM_WORDS];
  generate
    for (gi = 0; gi < MEM_WORDS; gi++) begin : g_rom
      assign mem[gi] = rom_pattern(gi);
    end
  endgenerate

  logic        in_range;
  logic [3:0]  nibble;
  logic [1:0]  pixel;
  logic [23:0] pal_color;
  logic [23:0] rgb_next;

  assign in_range = s1_addr_reg < AW'(2 * MEM_WORDS);
  assign nibble   = mem[s1_addr_reg[MW:1]];
  assign pixel    = !in_range ? mem[0][1:0] : (s1_addr_reg[0] ? nibble[3:2] : nibble[1:0]);

`ifdef TILE_BAND_PALETTE_WRITE_EN
  logic [23:0] palette_reg [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 4; p++) palette_reg[p] <= pal_default(2'(p));
    end else if (cfg_wr && (input_type == 3'b110)) begin
      palette_reg[child_comp[1:0]] <= {msg[11:8], msg[11:8], msg[7:4], msg[7:4],
                                       msg[3:0], msg[3:0]};
    end
  end

  assign pal_color = palette_reg[pixel];
`else
  logic unused_msg_bit;
  assign unused_msg_bit = msg[10];
  assign pal_color      = pal_default(pixel);
`endif

  assign rgb_next = s1_hit_reg ? pal_color : BG_COLOR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) RGB_output <= BG_COLOR;
    else       RGB_output <= rgb_next;
  end

endmodule

// File: tb/tb_tile_band_display.sv
// Directed bench for tile_band_display; ROM pixel(row,col) = col[3:2] + row[1:0] + col[0] mod 4.
module tb_tile_band_display;
  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [31:0] writedata;
  logic [9:0]  hcount, vcount;
  logic [23:0] rgb;

  localparam logic [23:0] BG = 24'h202020;
  localparam logic [23:0] WH = 24'hFFFFFF;
  localparam logic [23:0] GR = 24'h808080;
  localparam logic [23:0] LG = 24'hD3D3D3;

  int tests = 0;
  int fails = 0;

  tile_band_display dut (
    .clk(clk), .reset(reset), .write(write), .writedata(writedata),
    .hcount(hcount), .vcount(vcount), .RGB_output(rgb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] exp);
    tests++;
    assert (rgb === exp) else begin
      fails++;
      $error("FAIL %s: RGB_output=%h expected %h", tag, rgb, exp);
    end
    $display("[TB] %s RGB_output=%h expected=%h", tag, rgb, exp);
  endtask

  task automatic cmd(input logic [5:0] sub, input logic [4:0] child, input logic [3:0] info,
                     input logic [2:0] typ, input logic bs, input logic [12:0] msg);
    @(negedge clk);
    writedata = {sub, child, info, typ, bs, msg};
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic wr(input logic [4:0] child, input logic [2:0] typ, input logic bs,
                    input logic [12:0] msg);
    cmd(6'b001111, child, 4'h1, typ, bs, msg);
  endtask

  task automatic swap(input logic bs);
    cmd(6'b000000, 5'd0, 4'hF, 3'b000, bs, 13'd0);
  endtask

  task automatic pix(input int h, input int v, input string tag, input logic [23:0] exp);
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    @(posedge clk);
    @(posedge clk);
    #1 check(tag, exp);
  endtask

  task automatic commit_step();
    @(negedge clk);
    hcount = 10'd0;
    vcount = 10'd480;
    @(negedge clk);
    vcount = 10'd0;
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; writedata = 32'd0; hcount = 10'd0; vcount = 10'd0;
    repeat (3) @(posedge clk);
    #1 check("reset_rgb", BG);
    @(negedge clk) reset = 1'b0;
    pix(100, 368, "reset_disabled", BG);

    // Bank0 band0 at y=368
    wr(5'd0, 3'b011, 1'b0, 13'd368);
    wr(5'd0, 3'b001, 1'b0, 13'h1000);
    pix(100, 368, "b0_col4_row0", WH);
    pix(101, 368, "b0_col5_row0", GR);
    pix(100, 370, "b0_col4_row2", LG);
    pix(100, 367, "b0_above_top", BG);

    // Swap request mid-frame; commit only at line 480, hcount 0
    @(negedge clk) vcount = 10'd200;
    swap(1'b1);
    pix(100, 370, "pre_commit", LG);
    pix(5, 480, "line480_h5", BG);
    pix(100, 370, "no_commit_h5", LG);
    commit_step();
    pix(100, 368, "post_commit_bank1", BG);
    swap(1'b0);
    commit_step();
    pix(100, 368, "bank0_enable_cleared", BG);

    // Priority: band0 y=368, band1 y=380 scrolled by 4
    wr(5'd0, 3'b001, 1'b0, 13'h1000);
    wr(5'd1, 3'b011, 1'b0, 13'd380);
    wr(5'd1, 3'b010, 1'b0, 13'd4);
    wr(5'd1, 3'b001, 1'b0, 13'h1000);
    pix(96, 390, "prio_overlap", GR);
    pix(96, 399, "prio_band0_last", LG);
    pix(96, 400, "band1_row20", WH);
    wr(5'd1, 3'b001, 1'b0, 13'h0000);

    // Scroll and mirror
    wr(5'd0, 3'b010, 1'b0, 13'd5);
    pix(0, 368, "scroll5_h0", GR);
    pix(7, 368, "scroll5_h7", LG);
    pix(12, 368, "scroll5_wrap", WH);
    wr(5'd0, 3'b001, 1'b0, 13'h1800);
    pix(0, 368, "mirror_h0_col10", GR);
    pix(1, 368, "mirror_h1_col9", LG);
    wr(5'd0, 3'b001, 1'b0, 13'h1000);
    wr(5'd0, 3'b010, 1'b0, 13'd0);

    // Horizontal window
    wr(5'd0, 3'b100, 1'b0, 13'd100);
    wr(5'd0, 3'b101, 1'b0, 13'd200);
    pix(99, 368, "edge_h99", BG);
    pix(100, 368, "edge_h100", WH);
    pix(199, 368, "edge_h199", GR);
    pix(200, 368, "edge_h200", BG);
    wr(5'd0, 3'b100, 1'b0, 13'd300);
    wr(5'd0, 3'b101, 1'b0, 13'd300);
    pix(300, 368, "edge_empty_h300", BG);
    wr(5'd0, 3'b100, 1'b0, 13'd0);
    wr(5'd0, 3'b101, 1'b0, 13'd640);
    pix(100, 368, "edge_restored", WH);

    // Ignored writes
    cmd(6'b001111, 5'd4, 4'h1, 3'b001, 1'b0, 13'h0000);
    pix(100, 368, "ignore_child_oob", WH);
    cmd(6'b000001, 5'd0, 4'h1, 3'b001, 1'b0, 13'h0000);
    pix(100, 368, "ignore_sub_comp", WH);
    @(negedge clk) writedata = {6'b001111, 5'd0, 4'h1, 3'b001, 1'b0, 13'h0000};
    @(negedge clk);
    pix(100, 368, "ignore_write_low", WH);
    wr(5'd0, 3'b001, 1'b0, 13'h1001);
    pix(100, 368, "tile_sel_oob_kept", WH);

    // Later swap request overrides the earlier one
    swap(1'b1);
    swap(1'b0);
    commit_step();
    pix(100, 368, "pending_overwrite", WH);

    // Reset with a swap pending
    swap(1'b1);
    pix(100, 368, "pre_reset", WH);
    @(negedge clk) reset = 1'b1;
    #1 check("reset_async", BG);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("reset_2cyc", BG);
    wr(5'd0, 3'b011, 1'b0, 13'd368);
    wr(5'd0, 3'b001, 1'b0, 13'h1000);
    pix(100, 368, "post_reset_bank0", WH);
    commit_step();
    pix(100, 368, "no_swap_after_reset", WH);

    // Palette entry 1 write
    wr(5'd1, 3'b110, 1'b0, 13'h00F0);
`ifdef TILE_BAND_PALETTE_WRITE_EN
    pix(100, 368, "palette_write", 24'h00FF00);
`else
    pix(100, 368, "palette_write", WH);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tile_band_display.md
Name: tile_band_display

Overview:
- Parametrised successor to the single-ground-strip renderer.
- Draws NUM_BANDS independent horizontal tiled strips (ground, ceiling, platforms) from one 2-bpp on-chip tile ROM.
- Each band has its own Y position, horizontal scroll, mirror and enable, all held in ping-pong register banks.
- Bank swaps are deferred to the frame boundary, and the pixel path is pipelined with a registered output; it feeds the layer compositor alongside the other *_display blocks.

Parameters:
- COMPONENT_ID, 6'b001111, sub_comp value this block answers to
- NUM_BANDS, 4, number of bands (1..8)
- TILE_W, 16, tile width in pixels (power of 2)
- TILE_H, 32, band height in pixels (power of 2)
- MEM_WORDS, 256, tile ROM depth in 4-bit words (2 pixels per word)
- H_ACTIVE, 640, visible width; reset value of r_edge
- SWAP_LINE, 480, vcount at which a pending swap commits
- BG_COLOR, 24'h202020, colour outside any drawn pixel

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- write  in  1  strobe; writedata is decoded only in cycles where write=1
- writedata  in  32  command word
- hcount  in  10  current pixel column
- vcount  in  10  current line
- RGB_output  out  24  pixel colour, 2 cycles after hcount/vcount

Behaviour:
- Command fields:
  - sub_comp [31:26]
  - child_comp [25:21], the band index
  - info [20:17]
  - input_type [16:14]
  - buffer_state [13], the target bank
  - input_msg [12:0]
- info=4'hF (swap request, any sub_comp):
  - Latch pending_bank=buffer_state and set swap_pending=1.
  - At the cycle with vcount==SWAP_LINE && hcount==0: active_bank<=pending_bank, swap_pending<=0, and clear the enable of every band in the bank that just became shadow.
  - A second request before commit overwrites pending_bank; only one commit occurs.
- info=4'h1 with sub_comp==COMPONENT_ID and child_comp<NUM_BANDS writes bank[buffer_state], band[child_comp]. Other values are ignored; child_comp>=NUM_BANDS is ignored.
  - 001: enable=msg[12], mirror=msg[11], tile_sel=msg[4:0] (tile base = tile_sel*TILE_W*TILE_H pixels); tile_sel beyond ROM keeps the previous value.
  - 010: x_scroll=msg[9:0].
  - 011: band_y=msg[9:0].
  - 100: l_edge=msg[9:0] (global, unbanked).
  - 101: r_edge=msg[9:0] (global, unbanked).
- Writes to the active bank are legal and take effect immediately.
- If a write and a swap commit fall in the same cycle, the write lands in its addressed bank, and the commit's enable-clear wins for that bank.
- Stage 1 (registered):
  - For each band b, hit_b = enable && vcount in [band_y, band_y+TILE_H) && hcount in [l_edge, r_edge).
  - row = vcount-band_y, computed in 10-bit arithmetic.
  - col = (hcount+x_scroll) mod TILE_W, wrapping naturally; mirror gives col=TILE_W-1-col.
  - addr = base+row*TILE_W+col.
  - The lowest-index hit band wins; latch its addr and a hit flag.
  - band_y+TILE_H>1023 clips at 1023.
  - l_edge>=r_edge means no pixel is drawn.
- Stage 2 (registered):
  - If hit and addr<2*MEM_WORDS: nibble = mem[addr>>1]; pixel = addr[0] ? nibble[3:2] : nibble[1:0]; RGB_output = palette[pixel].
  - If hit and addr is out of range: palette[mem[0][1:0]].
  - If no hit: BG_COLOR.
- Default palette: 202020, FFFFFF, 808080, D3D3D3.
- Reset values:
  - RGB_output=BG_COLOR.
  - Pipeline hit flags=0.
  - active_bank=0, swap_pending=0.
  - All enable/mirror/tile_sel/x_scroll/band_y=0.
  - l_edge=0, r_edge=H_ACTIVE.
  - Palette returns to default.
- Reset mid-frame blanks within 2 cycles of deassertion; no partial swap survives reset.

Optional Feature:
- Macro: TILE_BAND_PALETTE_WRITE_EN.
- Defined:
  - input_type 110 with child_comp[1:0]=entry writes palette[entry] = RGB444 msg[11:0] expanded by nibble replication (e.g. 0xF80 -> FF8800).
  - Unbanked; takes effect on the next stage-2 cycle.
- Undefined: palette is constant default; input_type 110 is ignored.

Test Plan:
1. Reset, then a type-001 write to bank0 band0 with enable=1 and band_y=368, no swap. Required: pixels at (100,368) render from bank0. Then a swap request with buffer_state=1 at vcount=200. Required: bank0 still drawn through line 479; from line 480 on, BG_COLOR, since bank1 is empty and bank0's enable is cleared.
2. Band0 at y=368, band1 at y=380, both enabled. Required: lines 380..399 show band0 content (priority); line 400 shows band1 row 20.
3. x_scroll=5 vs 0. Required: pixel at hcount=h equals the unscrolled pixel at h+5 mod 16. With mirror=1, hcount=0 samples col 15-5=10.
4. l_edge=100, r_edge=200. Required: hcount 99 and 200 give BG_COLOR; hcount 100 and 199 give tile colour. With l_edge=r_edge=300, the whole band is BG_COLOR.
5. Write with child_comp=NUM_BANDS, write with wrong sub_comp, and writedata change with write=0. Required: no state change. Assert reset during a pending swap. Required: active_bank=0 and RGB_output=BG_COLOR 2 cycles later.
6. With TILE_BAND_PALETTE_WRITE_EN, write entry1=0x0F0. Required: white pixels become 00FF00. Without the macro, the same write leaves them FFFFFF.
